// File: rtl/mips_hazard_scoreboard.sv
// Hazard/forwarding controller: a shift-register scoreboard of in-flight register
// writers drives the load-use stall, the branch flush and registered EX forward selects.
module mips_hazard_scoreboard #(
  parameter int REG_ADDR_W  = 5,
  parameter int DEPTH       = 3,
  parameter int LOAD_READY  = 3,
  parameter int BRANCH_SLOT = 2,
  parameter int CNT_W       = 16,
  localparam int FWD_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic [FWD_W-1:0]      ex_fwd_a,
  output logic [FWD_W-1:0]      ex_fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic                  slot_vld [1:DEPTH];
  logic [REG_ADDR_W-1:0] slot_dst [1:DEPTH];
  logic                  slot_rw  [1:DEPTH];
  logic                  slot_ld  [1:DEPTH];

  int   prod_a;
  int   prod_b;
  logic block_a;
  logic block_b;
  logic take_id;

  // Scan oldest to youngest so the lowest matching slot is the one kept; r0 never matches.
  function automatic int youngest(input logic [REG_ADDR_W-1:0] src, input logic used);
    int found;
    found = 0;
    if (used && src != '0) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (slot_vld[k] && slot_rw[k] && slot_dst[k] == src) found = k;
      end
    end
    return found;
  endfunction

  function automatic logic load_blocks(input int k);
    logic blk;
    blk = 1'b0;
    for (int j = 1; j <= DEPTH; j++) begin
      if (j == k && slot_ld[j] && (j + 1 < LOAD_READY)) blk = 1'b1;
    end
    return blk;
  endfunction

  // The producer advances one slot on the same edge the consumer enters EX.
  function automatic logic [FWD_W-1:0] fwd_sel(input int k);
    if (k != 0 && k + 1 <= DEPTH) return FWD_W'(k + 1);
    return '0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  always_comb begin
    prod_a  = youngest(id_rs, id_uses_rs);
    prod_b  = youngest(id_rt, id_uses_rt);
    block_a = load_blocks(prod_a);
    block_b = load_blocks(prod_b);
    flush   = !rst && branch_taken;
    stall   = !rst && id_valid && !branch_taken && (block_a || block_b);
    take_id = id_valid && !stall && !flush;
  end

  // Slot shift boundary: control bits, forward selects and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) slot_vld[k] <= 1'b0;
      ex_fwd_a  <= '0;
      ex_fwd_b  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      slot_vld[1] <= take_id;
      for (int k = 2; k <= DEPTH; k++)
        slot_vld[k] <= slot_vld[k-1] && !(flush && (k - 1 < BRANCH_SLOT));
      ex_fwd_a <= take_id ? fwd_sel(prod_a) : '0;
      ex_fwd_b <= take_id ? fwd_sel(prod_b) : '0;
      if (stall) stall_cnt <= sat_inc(stall_cnt);
      if (flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  // Slot shift boundary: payload fields, only meaningful while the slot is valid
  always_ff @(posedge clk) begin
    slot_dst[1] <= id_dst;
    slot_rw[1]  <= id_reg_write;
    slot_ld[1]  <= id_mem_read;
    for (int k = 2; k <= DEPTH; k++) begin
      slot_dst[k] <= slot_dst[k-1];
      slot_rw[k]  <= slot_rw[k-1];
      slot_ld[k]  <= slot_ld[k-1];
    end
  end

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Table-driven bench for mips_hazard_scoreboard (DEPTH=3, LOAD_READY=3, BRANCH_SLOT=2, CNT_W=2).
module tb_mips_hazard_scoreboard;
  localparam int AW = 5;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, branch_taken;
  logic [AW-1:0] id_rs, id_rt, id_dst;
  logic          stall, flush;
  logic [1:0]    ex_fwd_a, ex_fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_hazard_scoreboard #(
    .REG_ADDR_W(AW), .DEPTH(3), .LOAD_READY(3), .BRANCH_SLOT(2), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
    .stall(stall), .flush(flush), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic          v;
    logic [AW-1:0] rs, rt;
    logic          urs, urt;
    logic [AW-1:0] dst;
    logic          rw, mr, bt;
    logic          st, fl;
    logic [1:0]    fa, fb;
    int            sc, fc;
  } vec_t;

  typedef struct {
    logic [1:0] fa, fb;
    int         sc, fc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(input int v, rs, rt, urs, urt, dst, rw, mr, bt,
                              st, fl, fa, fb, sc, fc);
    vec_t x;
    x.v = 1'(v);    x.rs = AW'(rs); x.rt = AW'(rt); x.urs = 1'(urs); x.urt = 1'(urt);
    x.dst = AW'(dst); x.rw = 1'(rw); x.mr = 1'(mr); x.bt = 1'(bt);
    x.st = 1'(st);  x.fl = 1'(fl);  x.fa = 2'(fa);  x.fb = 2'(fb);
    x.sc = sc;      x.fc = fc;
    return x;
  endfunction

  function automatic vec_t bub(input int sc, fc);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, sc, fc);
  endfunction

  function automatic int sat(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_dst = 0; id_reg_write = 0; id_mem_read = 0; branch_taken = 0;
  endtask

  task automatic apply(input vec_t x, input string tag);
    exp_t e;
    @(negedge clk);
    id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_uses_rs = x.urs; id_uses_rt = x.urt;
    id_dst = x.dst; id_reg_write = x.rw; id_mem_read = x.mr; branch_taken = x.bt;
    #1;
    chk({tag, ".stall"}, int'(stall), int'(x.st));
    chk({tag, ".flush"}, int'(flush), int'(x.fl));
    e.fa = x.fa; e.fb = x.fb; e.sc = x.sc; e.fc = x.fc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".fwd_a"}, int'(ex_fwd_a), int'(e.fa));
    chk({tag, ".fwd_b"}, int'(ex_fwd_b), int'(e.fb));
    chk({tag, ".stall_cnt"}, int'(stall_cnt), e.sc);
    chk({tag, ".flush_cnt"}, int'(flush_cnt), e.fc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", int'(stall), 0);
    chk("rst.fwd_a", int'(ex_fwd_a), 0);
    chk("rst.fwd_b", int'(ex_fwd_b), 0);
    chk("rst.stall_cnt", int'(stall_cnt), 0);
    chk("rst.flush_cnt", int'(flush_cnt), 0);
    branch_taken = 1;
    #1;
    chk("rst.flush_gated", int'(flush), 0);
    branch_taken = 0;
    @(negedge clk);
    rst = 0;

    //               v rs rt urs urt dst rw mr bt st fl fa fb sc fc
    tbl.push_back(mk(1, 1, 2, 1, 1,  3, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // add r3
    tbl.push_back(mk(1, 3, 1, 1, 1,  4, 1, 0, 0, 0, 0, 2, 0, 0, 0)); // sub r4,r3,r1
    repeat (3) tbl.push_back(bub(0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0,  5, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // lw r5
    tbl.push_back(mk(1, 5, 5, 1, 1,  6, 1, 0, 0, 1, 0, 0, 0, 1, 0)); // add r6,r5,r5 stalls
    tbl.push_back(mk(1, 5, 5, 1, 1,  6, 1, 0, 0, 0, 0, 3, 3, 1, 0)); // retry forwards from MEM
    repeat (3) tbl.push_back(bub(1, 0));
    tbl.push_back(mk(1, 1, 2, 1, 1,  7, 1, 0, 0, 0, 0, 0, 0, 1, 0)); // add r7
    tbl.push_back(mk(1, 7, 1, 1, 1,  7, 1, 0, 0, 0, 0, 2, 0, 1, 0)); // or r7,r7,r1
    tbl.push_back(mk(1, 7, 7, 1, 1, 10, 1, 0, 0, 0, 0, 2, 2, 1, 0)); // younger r7 wins
    tbl.push_back(mk(1, 7, 10, 1, 1, 0, 1, 0, 0, 0, 0, 3, 2, 1, 0)); // add r0,r7,r10
    tbl.push_back(mk(1, 7, 0, 1, 0,  0, 1, 1, 0, 0, 0, 0, 0, 1, 0)); // r7 three back -> regfile
    tbl.push_back(mk(1, 0, 10, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 1, 0)); // r0 after lw r0; r10 too far
    repeat (3) tbl.push_back(bub(1, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 12, 1, 1, 0, 0, 0, 0, 0, 1, 0)); // lw r12
    tbl.push_back(mk(1, 12, 1, 1, 1, 13, 1, 0, 1, 0, 1, 0, 0, 1, 1)); // branch over load-use
    tbl.push_back(mk(1, 12, 13, 1, 1, 14, 1, 0, 0, 0, 0, 0, 0, 1, 1)); // flushed producers gone
    tbl.push_back(mk(1, 14, 14, 0, 1, 15, 0, 0, 0, 0, 0, 0, 2, 1, 1)); // unused rs ignored
    tbl.push_back(mk(1, 15, 14, 1, 1, 16, 1, 0, 0, 0, 0, 0, 3, 1, 1)); // non-writer not a producer
    repeat (3) tbl.push_back(bub(1, 1));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;

    for (int i = 0; i < 5; i++) begin
      apply(mk(1, 1, 0, 1, 0, 14, 1, 1, 0, 0, 0, 0, 0, sat(i), 0), $sformatf("sat_lw%0d", i));
      apply(mk(1, 14, 1, 1, 1, 15, 1, 0, 0, 1, 0, 0, 0, sat(i + 1), 0), $sformatf("sat_use%0d", i));
      apply(mk(1, 14, 1, 1, 1, 15, 1, 0, 0, 0, 0, 3, 0, sat(i + 1), 0), $sformatf("sat_retry%0d", i));
    end
    for (int j = 0; j < 4; j++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 3, sat(j + 1)), $sformatf("fsat%0d", j));

    apply(mk(1, 1, 0, 1, 0, 14, 1, 1, 0, 0, 0, 0, 0, 3, 3), "arst_lw");
    @(negedge clk);
    id_valid = 1; id_rs = 14; id_rt = 1; id_uses_rs = 1; id_uses_rt = 1;
    id_dst = 15; id_reg_write = 1; id_mem_read = 0; branch_taken = 0;
    #1;
    chk("arst.stall_before", int'(stall), 1);
    #1;
    rst = 1;
    #1;
    chk("arst.stall", int'(stall), 0);
    chk("arst.stall_cnt", int'(stall_cnt), 0);
    chk("arst.flush_cnt", int'(flush_cnt), 0);
    branch_taken = 1;
    #1;
    chk("arst.flush", int'(flush), 0);
    idle();
    @(negedge clk);
    rst = 0;
    apply(mk(1, 14, 1, 1, 1, 15, 1, 0, 0, 0, 0, 0, 0, 0, 0), "arst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_hazard_scoreboard.md
Name: mips_hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the pipelined MIPS core, generalised to any pipeline depth.
- Tracks in-flight register writers in a shift-register scoreboard, one slot per post-ID stage.
- Generates load-use stalls, branch flushes and registered forwarding selects for the EX operands.
- Sits beside the ID stage and drives the PC/IF_ID hold, the ID_EX bubble and the EX operand muxes.

Parameters:
- REG_ADDR_W, 5: register specifier width.
- DEPTH, 3: scoreboard slots. Slot 1 = EX, slot 2 = MEM, slot DEPTH = last stage before regfile write.
- LOAD_READY, 3: first slot from which load data can be forwarded.
- BRANCH_SLOT, 2: slot in which branches resolve; slots below it are flushed.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_ADDR_W  source A specifier.
- id_rt  in  REG_ADDR_W  source B specifier.
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_dst  in  REG_ADDR_W  destination specifier (after RegDst mux).
- id_reg_write  in  1  instruction writes a register.
- id_mem_read  in  1  instruction is a load.
- branch_taken  in  1  branch in BRANCH_SLOT resolved taken this cycle.
- stall  out  1  hold PC and IF_ID, bubble into ID_EX.
- flush  out  1  clear IF_ID and ID_EX this cycle.
- ex_fwd_a  out  clog2(DEPTH+1)  EX operand A source: 0 = regfile, j = result of slot j.
- ex_fwd_b  out  clog2(DEPTH+1)  EX operand B source, same encoding.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of flushes.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: all slots invalid, ex_fwd_a = 0, ex_fwd_b = 0, stall_cnt = 0, flush_cnt = 0. stall and flush are 0 while rst is high.
- Slot contents: {valid, dst, reg_write, is_load}.
- Slot shift: every edge, slot k moves to k+1 and slot DEPTH is discarded.
- Slot 1 load: gets the ID instruction when id_valid, !stall and !flush; otherwise it gets a bubble (valid = 0).
- Producer match for a source s:
  - A slot k matches if valid, reg_write, dst == s and s != 0.
  - The youngest match (lowest k) wins.
  - No match, or source unused, means no producer.
- Stall (combinational): asserted when id_valid, !branch_taken, and either used source has its youngest producer as a load with k+1 < LOAD_READY.
- Flush (combinational): flush = branch_taken.
  - At the edge, slots 1..BRANCH_SLOT-1 are invalidated before the shift, so the shifted-in slot 1 is a bubble.
  - Flush overrides stall in the same cycle: stall = 0.
- Forwarding (registered at the edge that moves the instruction into slot 1):
  - ex_fwd_x = k+1 if a producer exists at slot k and k+1 <= DEPTH, else 0.
  - On bubble or flush, ex_fwd_x <= 0.
- The regfile is write-through. A producer that has left slot DEPTH is read as source 0.
- r0 never matches, never stalls and never forwards.
- Counters:
  - stall_cnt increments on each edge where stall = 1.
  - flush_cnt increments on each edge where flush = 1.
  - Both saturate at 2^CNT_W - 1 with no wrap.
- Reset mid-operation clears all scoreboard slots immediately and drops stall and flush the same cycle.

Test Plan:
- Back-to-back ALU dependency: add r3 then sub r4,r3,r1 -> no stall; ex_fwd_a = 2 in the cycle sub is in EX.
- Load-use: lw r5 then add r6,r5,r5 -> stall = 1 for exactly 1 cycle, stall_cnt = 1; then ex_fwd_a = 3 and ex_fwd_b = 3.
- Double producer: add r7 followed by or r7, then use r7 -> forward from the younger writer, ex_fwd_a = 2, not 3.
- r0 and distance: writes to r0 never stall or forward. A producer 3 instructions back with DEPTH = 3 gives ex_fwd = 0.
- Branch flush: branch_taken = 1 while a load-use stall is pending -> flush = 1, stall = 0, flush_cnt = 1, next ex_fwd = 0, slot 1 invalid.
- Saturation and reset: CNT_W = 2 with 5 stall cycles -> stall_cnt = 3. Assert rst asynchronously mid-stall -> stall = 0 immediately, counters = 0.
